// File: rtl/nios_mul_pipe.sv
// rtl/nios_mul_pipe.sv - pipelined DATA_W x DATA_W multiplier returning the low or high product word
module nios_mul_pipe #(
    parameter int    DATA_W        = 32,
    parameter int    OUT_REG       = 0,
    parameter string DEVICE_FAMILY = "CYCLONE10LP"
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        mode,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    localparam int HALF = DATA_W / 2;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULXSS = 2'b11;

    function automatic logic [DATA_W-1:0] umul(input logic [HALF-1:0] x, input logic [HALF-1:0] y);
        return {{HALF{1'b0}}, x} * {{HALF{1'b0}}, y};
    endfunction

    logic [HALF-1:0] a_lo, a_hi, b_lo, b_hi;
    assign a_lo = src1[HALF-1:0];
    assign a_hi = src1[DATA_W-1:HALF];
    assign b_lo = src2[HALF-1:0];
    assign b_hi = src2[DATA_W-1:HALF];

    logic [DATA_W-1:0] ll_d, lh_d, hl_d, hh_d;

    generate
        if (DEVICE_FAMILY == "GENERIC") begin : g_pp_plain
            assign ll_d = umul(a_lo, b_lo);
            assign lh_d = umul(a_lo, b_hi);
            assign hl_d = umul(a_hi, b_lo);
            assign hh_d = umul(a_hi, b_hi);
        end else begin : g_pp_dsp
            (* multstyle = "dsp" *) logic [DATA_W-1:0] ll_m, lh_m, hl_m, hh_m;
            assign ll_m = umul(a_lo, b_lo);
            assign lh_m = umul(a_lo, b_hi);
            assign hl_m = umul(a_hi, b_lo);
            assign hh_m = umul(a_hi, b_hi);
            assign ll_d = ll_m;
            assign lh_d = lh_m;
            assign hl_d = hl_m;
            assign hh_d = hh_m;
        end
    endgenerate

    // Signed operands are treated as unsigned and fixed up in the high word:
    // a negative A costs B<<DATA_W, a negative B costs A<<DATA_W.
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] corr_d;
    assign a_neg  = mode[1] & src1[DATA_W-1];
    assign b_neg  = (mode == MODE_MULXSS) & src2[DATA_W-1];
    assign corr_d = (a_neg ? src2 : '0) + (b_neg ? src1 : '0);

    logic [DATA_W-1:0] ll_q, lh_q, hl_q, hh_q, corr_q;
    logic [1:0]        mode_q;
    logic              v1_q, v1_d;

    always_comb begin
        v1_d = v1_q;
        if (flush)
            v1_d = 1'b0;
        else if (en)
            v1_d = in_valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ll_q   <= '0;
            lh_q   <= '0;
            hl_q   <= '0;
            hh_q   <= '0;
            corr_q <= '0;
            mode_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (en) begin
                ll_q   <= ll_d;
                lh_q   <= lh_d;
                hl_q   <= hl_d;
                hh_q   <= hh_d;
                corr_q <= corr_d;
                mode_q <= mode;
            end
        end
    end

    // The middle sum keeps its carry bit so it can propagate into the high word.
    logic [DATA_W:0]     mid_sum;
    logic [2*DATA_W-1:0] prod;
    assign mid_sum = {1'b0, lh_q} + {1'b0, hl_q};
    assign prod    = {{DATA_W{1'b0}}, ll_q}
                   + ({{(DATA_W-1){1'b0}}, mid_sum} << HALF)
                   + {hh_q, {DATA_W{1'b0}}}
                   - {corr_q, {DATA_W{1'b0}}};

    logic [DATA_W-1:0] res2_d, res2_q;
    logic              v2_d, v2_q;
    assign res2_d = (mode_q == MODE_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];

    always_comb begin
        v2_d = v2_q;
        if (flush)
            v2_d = 1'b0;
        else if (en)
            v2_d = v1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            v2_q <= v2_d;
            if (en)
                res2_q <= res2_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] res3_q;
            logic              v3_q, v3_d;

            always_comb begin
                v3_d = v3_q;
                if (flush)
                    v3_d = 1'b0;
                else if (en)
                    v3_d = v2_q;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    res3_q <= '0;
                    v3_q   <= 1'b0;
                end else begin
                    v3_q <= v3_d;
                    if (en)
                        res3_q <= res2_q;
                end
            end

            assign out_valid = v3_q;
            assign result    = res3_q;
        end else begin : g_out_direct
            assign out_valid = v2_q;
            assign result    = res2_q;
        end
    endgenerate

    assign busy = v1_q | ((OUT_REG != 0) & v2_q);

endmodule

// File: tb/tb_nios_mul_pipe.sv
// tb/tb_nios_mul_pipe.sv - directed vector bench for nios_mul_pipe (32-bit direct and 16-bit registered outputs)
module tb_nios_mul_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        flush;

    logic        iv32;
    logic [31:0] a32, b32;
    logic [1:0]  m32;
    logic        ov32, busy32;
    logic [31:0] res32;

    logic        iv16;
    logic [15:0] a16, b16;
    logic [1:0]  m16;
    logic        ov16, busy16;
    logic [15:0] res16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nios_mul_pipe #(.DATA_W(32), .OUT_REG(0)) dut32 (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
        .in_valid(iv32), .src1(a32), .src2(b32), .mode(m32),
        .out_valid(ov32), .result(res32), .busy(busy32)
    );

    nios_mul_pipe #(.DATA_W(16), .OUT_REG(1)) dut16 (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
        .in_valid(iv16), .src1(a16), .src2(b16), .mode(m16),
        .out_valid(ov16), .result(res16), .busy(busy16)
    );

    typedef struct {
        bit          narrow;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        iv32 = v;
        a32  = a;
        b32  = b;
        m32  = m;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        logic        ov;
        logic [31:0] res;
        lat = v.narrow ? 3 : 2;
        @(negedge clk);
        if (v.narrow) begin
            iv16 = 1'b1; a16 = v.a[15:0]; b16 = v.b[15:0]; m16 = v.mode;
        end else begin
            drive32(1'b1, v.a, v.b, v.mode);
        end
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            iv16 = 1'b0;
            iv32 = 1'b0;
            ov  = v.narrow ? ov16 : ov32;
            res = v.narrow ? {16'h0, res16} : res32;
            if (c == lat) begin
                chk($sformatf("vec%0d out_valid", idx), {31'h0, ov}, 32'h1);
                chk($sformatf("vec%0d result", idx), res, v.exp);
            end else begin
                chk($sformatf("vec%0d out_valid c%0d", idx, c), {31'h0, ov}, 32'h0);
            end
        end
    endtask

    logic [31:0] b2b_a[4], b2b_b[4], b2b_exp[4];
    logic [1:0]  b2b_m[4];

    initial begin
        vecs[0]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 2'b01, 32'h0000_0001};
        vecs[2]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 2'b10, 32'hFFFF_FFFF};
        vecs[8]  = '{1'b0, 32'h0000_0002, 32'h8000_0000, 2'b10, 32'h0000_0001};
        vecs[9]  = '{1'b0, 32'h0000_0002, 32'h8000_0000, 2'b11, 32'hFFFF_FFFF};
        vecs[10] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 32'h0B00_EA4E};
        vecs[11] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFF9};
        vecs[12] = '{1'b1, 32'h0000_FFFF, 32'h0000_0002, 2'b10, 32'h0000_FFFF};
        vecs[13] = '{1'b1, 32'h0000_FFFF, 32'h0000_0002, 2'b01, 32'h0000_0001};
        vecs[14] = '{1'b1, 32'h0000_8000, 32'h0000_8000, 2'b11, 32'h0000_4000};
        vecs[15] = '{1'b1, 32'h0000_00FF, 32'h0000_0101, 2'b00, 32'h0000_FFFF};

        b2b_a = '{32'h3, 32'h8000_0000, 32'h1234_5678, 32'h7};
        b2b_b = '{32'h5, 32'h8000_0000, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
        b2b_m = '{2'b00, 2'b11, 2'b01, 2'b00};
        b2b_exp = '{32'd15, 32'h4000_0000, 32'h0B00_EA4E, 32'hFFFF_FFF9};

        reset_n = 1'b0;
        en      = 1'b1;
        flush   = 1'b0;
        drive32(1'b0, '0, '0, 2'b00);
        iv16 = 1'b0; a16 = '0; b16 = '0; m16 = 2'b00;
        #1;
        chk("reset out_valid32", {31'h0, ov32}, 32'h0);
        chk("reset busy32", {31'h0, busy32}, 32'h0);
        chk("reset result32", res32, 32'h0);
        chk("reset out_valid16", {31'h0, ov16}, 32'h0);
        chk("reset busy16", {31'h0, busy16}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_vec(vecs[i], i);

        // back-to-back issue: results on four consecutive cycles
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                chk($sformatf("b2b out_valid c%0d", c), {31'h0, ov32}, 32'h1);
                chk($sformatf("b2b result c%0d", c), res32, b2b_exp[c-2]);
            end else begin
                chk($sformatf("b2b idle c%0d", c), {31'h0, ov32}, 32'h0);
            end
            if (c < 4) drive32(1'b1, b2b_a[c], b2b_b[c], b2b_m[c]);
            else       drive32(1'b0, '0, '0, 2'b00);
        end

        // stall: first result held for three stalled cycles, second follows once
        @(negedge clk);
        drive32(1'b1, 32'h3, 32'h5, 2'b00);
        @(negedge clk);
        drive32(1'b1, 32'h0001_0000, 32'h0001_0000, 2'b01);
        @(negedge clk);
        drive32(1'b0, '0, '0, 2'b00);
        chk("stall first valid", {31'h0, ov32}, 32'h1);
        chk("stall first result", res32, 32'd15);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) iv32 = 1'b1;
            else        iv32 = 1'b0;
            chk($sformatf("stall hold valid c%0d", c), {31'h0, ov32}, 32'h1);
            chk($sformatf("stall hold result c%0d", c), res32, 32'd15);
            chk($sformatf("stall busy c%0d", c), {31'h0, busy32}, 32'h1);
        end
        en = 1'b1;
        @(negedge clk);
        chk("stall second valid", {31'h0, ov32}, 32'h1);
        chk("stall second result", res32, 32'h1);
        @(negedge clk);
        chk("stall no dup", {31'h0, ov32}, 32'h0);
        chk("stall busy clear", {31'h0, busy32}, 32'h0);

        // flush kills both in-flight ops; the next op completes
        @(negedge clk);
        drive32(1'b1, 32'h3, 32'h5, 2'b00);
        @(negedge clk);
        drive32(1'b1, 32'h7, 32'h7, 2'b00);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive32(1'b1, 32'h0000_0009, 32'h0000_0009, 2'b00);
        chk("flush c2 valid", {31'h0, ov32}, 32'h0);
        @(negedge clk);
        drive32(1'b0, '0, '0, 2'b00);
        chk("flush c3 valid", {31'h0, ov32}, 32'h0);
        @(negedge clk);
        chk("flush next valid", {31'h0, ov32}, 32'h1);
        chk("flush next result", res32, 32'd81);
        @(negedge clk);
        chk("flush next single", {31'h0, ov32}, 32'h0);

        // flush during a stall still clears valid bits
        @(negedge clk);
        drive32(1'b1, 32'h3, 32'h5, 2'b00);
        @(negedge clk);
        drive32(1'b0, '0, '0, 2'b00);
        en    = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        en    = 1'b1;
        flush = 1'b0;
        chk("stall flush busy", {31'h0, busy32}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall flush valid c%0d", c), {31'h0, ov32}, 32'h0);
        end

        // asynchronous reset mid-flight
        @(negedge clk);
        drive32(1'b1, 32'h3, 32'h5, 2'b00);
        @(negedge clk);
        drive32(1'b1, 32'h7, 32'h7, 2'b00);
        @(negedge clk);
        drive32(1'b0, '0, '0, 2'b00);
        chk("pre-reset valid", {31'h0, ov32}, 32'h1);
        chk("pre-reset busy", {31'h0, busy32}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset valid", {31'h0, ov32}, 32'h0);
        chk("async reset busy", {31'h0, busy32}, 32'h0);
        chk("async reset result", res32, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset valid c%0d", c), {31'h0, ov32}, 32'h0);
            chk($sformatf("post-reset result c%0d", c), res32, 32'h0);
        end
        run_vec(vecs[6], 100);
        run_vec(vecs[12], 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_mul_pipe.md
Name: nios_mul_pipe

Overview:
Parametrised, pipelined integer multiplier for the Nios II execute/memory path. It replaces the fixed 16x16 three-partial-product cell with a complete product unit. The unit splits operands into halves for hard DSP multipliers, sums the partial products internally, and returns the low or high word under signed or unsigned operand modes. The pipeline carries valid and mode tokens, and it supports stall (enable) and flush.

Parameters:
- DATA_W, 32, operand and result width; even; legal range 8..64; HALF = DATA_W/2.
- OUT_REG, 0, 1 adds an output register stage; latency = 2 + OUT_REG.
- DEVICE_FAMILY, "CYCLONE10LP", passed to the DSP inference attributes only; no functional effect.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance enable (stall when 0).
- flush  in  1  synchronous kill of all in-flight tokens.
- in_valid  in  1  src1/src2/mode are valid this cycle.
- src1  in  DATA_W  operand A.
- src2  in  DATA_W  operand B.
- mode  in  2  operation select: 00 MUL (low word), 01 MULXUU (high word, unsigned x unsigned), 10 MULXSU (high word, signed A x unsigned B), 11 MULXSS (high word, signed x signed).
- out_valid  out  1  result is valid.
- result  out  DATA_W  selected word of the product.
- busy  out  1  at least one valid token is in flight in an internal stage (excludes the output).

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - reset_n is asynchronous and active-low. While it is low, all stage valid bits, out_valid, busy and result are 0, and all partial-product registers are 0.
  - Reset asserted mid-operation discards every in-flight token. No output appears after reset deasserts.
- Exact arithmetic:
  - P = A' x B' computed to 2*DATA_W bits.
  - A' is src1 interpreted as signed for modes 10 and 11, otherwise unsigned.
  - B' is src2 interpreted as signed for mode 11 only.
  - MUL: result = P[DATA_W-1:0]. This word is mode-independent.
  - High modes: result = P[2*DATA_W-1:DATA_W].
- Stage S1 (on a clk edge with en=1):
  - Register the four HALF x HALF unsigned partial products LL, LH, HL, HH.
  - Register the sign-correction terms: subtract B<<DATA_W when A' is negative, and A<<DATA_W when B' is negative.
  - Register the mode and v1 = in_valid & ~flush.
- Stage S2 (on a clk edge with en=1):
  - Sum = LL + (LH+HL)<<HALF + HH<<DATA_W − corrections, modulo 2^(2*DATA_W).
  - Select the word by the S1 mode; v2 = v1 & ~flush.
  - With OUT_REG=0, S2 drives result/out_valid directly.
- Stage S3 (OUT_REG=1 only): same enable and flush rules as S2.
- Stall:
  - en=0 freezes every stage: data, mode and valid hold, and in_valid is ignored (no capture).
  - out_valid and result hold their values through the stall.
  - A consumer that samples while en=1 sees each token exactly once.
- Flush:
  - flush=1 with en=1 clears every stage valid bit on that edge; out_valid is 0 on the next cycle.
  - flush=1 with en=0 also clears all valid bits. Flush has priority over stall for valid bits; data registers may hold.
  - in_valid in the same cycle as flush is dropped.
- result is don't-care when out_valid=0. The bench checks result only when out_valid=1.
- Throughput: one operation per enabled cycle, with no bubbles between back-to-back operations.
- Boundary cases:
  - Most-negative operands (0x8000_0000 x 0x8000_0000 under MULXSS) produce an exact P = 2^62, so result = 0x4000_0000.
  - Carries from the LH+HL sum into the high word are required.
- busy = v1 | (OUT_REG ? v2 : 0), registered.

Test Plan:
1. DATA_W=32, OUT_REG=0: in_valid pulse with src1=0x0001_0000, src2=0x0001_0000, mode=00 -> out_valid two cycles later, result=0x0000_0000. Repeat with mode=01 -> result=0x0000_0001.
2. src1=src2=0xFFFF_FFFF: mode=11 -> result=0x0000_0000; mode=01 -> result=0xFFFF_FFFE; mode=10 -> result=0xFFFF_FFFF; mode=00 -> result=0x0000_0001.
3. Back-to-back: 4 consecutive ops (3x5 MUL, 0x8000_0000x0x8000_0000 MULXSS, 0x1234_5678x0x9ABC_DEF0 MULXUU, 7x(−1) MUL) -> results 15, 0x4000_0000, 0x0B00_EA4E, 0xFFFF_FFF9 on 4 consecutive cycles with no gap.
4. Stall: issue 2 ops, then drop en for 3 cycles after the first is in S2 -> out_valid/result hold steady for 3 cycles. After en=1 the two results emerge in order, no duplicates, no loss.
5. Flush/reset: issue 2 ops, assert flush one cycle later -> no out_valid for either op; an op issued the cycle after flush completes normally. Separately, pulse reset_n low mid-flight -> out_valid, busy and result are 0 immediately (asynchronous) and stay 0 until a new op.
6. OUT_REG=1, DATA_W=16: src1=0xFFFF, src2=0x0002, mode=10 -> out_valid three cycles later, result=0xFFFF. Repeat with mode=01 -> result=0x0001.
